// File: rtl/hilo_div_unit.sv
// HI/LO register pair with read bypass, plus an iterative radix-2 restoring
// divider (DIV/DIVU) that stalls the front of the pipe until its result is ready.
module hilo_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_startE,
  input  logic             div_signedE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             div_cancel,
  output logic             div_stall,
  output logic             div_ready,
  output logic [WIDTH-1:0] div_hi,
  output logic [WIDTH-1:0] div_lo,
  input  logic             HiLoWriteW,
  input  logic [WIDTH-1:0] hi_inW,
  input  logic [WIDTH-1:0] lo_inW,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] quot_q, rem_q, dvs_q;
  logic             qneg_q, rneg_q;
  logic             ready_q;
  logic [WIDTH-1:0] res_hi_q, res_lo_q;
  logic [WIDTH-1:0] hi_q, lo_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_d, quot_d, q_fix, r_fix;

  always_comb begin
    a_neg   = div_signedE & srcaE[WIDTH-1];
    b_neg   = div_signedE & srcbE[WIDTH-1];
    a_mag   = a_neg ? -srcaE : srcaE;
    b_mag   = b_neg ? -srcbE : srcbE;
    // Partial remainder is always below the divisor, so one extra bit holds the shifted value.
    shifted = {rem_q, quot_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[WIDTH];
    rem_d   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quot_d  = {quot_q[WIDTH-2:0], ge};
    q_fix   = qneg_q ? -quot_d : quot_d;
    r_fix   = rneg_q ? -rem_d : rem_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      ready_q  <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
    end else begin
      ready_q <= 1'b0;
      if (div_cancel) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (div_startE) begin
              if (srcbE == '0) begin
                state_q  <= DONE;
                ready_q  <= 1'b1;
                res_lo_q <= '1;
                res_hi_q <= srcaE;
              end else begin
                state_q <= BUSY;
                count_q <= '0;
                quot_q  <= a_mag;
                rem_q   <= '0;
                dvs_q   <= b_mag;
                qneg_q  <= a_neg ^ b_neg;
                rneg_q  <= a_neg;
              end
            end
          end
          BUSY: begin
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            count_q <= count_q + 1'b1;
            if (count_q == LAST) begin
              state_q  <= DONE;
              ready_q  <= 1'b1;
              res_lo_q <= q_fix;
              res_hi_q <= r_fix;
            end
          end
          DONE:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (HiLoWriteW) begin
      hi_q <= hi_inW;
      lo_q <= lo_inW;
    end
  end

  always_comb begin
    // Gated by reset so the stall drops immediately even with a start pending.
    div_stall = rst & (((state_q == IDLE) & div_startE & ~div_cancel) | (state_q == BUSY));
    div_ready = ready_q;
    div_hi    = res_hi_q;
    div_lo    = res_lo_q;
    hi_o      = HiLoWriteW ? hi_inW : hi_q;
    lo_o      = HiLoWriteW ? lo_inW : lo_q;
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: vector table through a result scoreboard,
// plus hand sequences for cancel, HI/LO bypass and mid-divide reset.
module tb_hilo_div_unit;

  localparam int unsigned W = 32;

  logic         clk, rst;
  logic         div_startE, div_signedE, div_cancel;
  logic [W-1:0] srcaE, srcbE;
  logic         div_stall, div_ready;
  logic [W-1:0] div_hi, div_lo;
  logic         HiLoWriteW;
  logic [W-1:0] hi_inW, lo_inW, hi_o, lo_o;

  hilo_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .div_startE(div_startE), .div_signedE(div_signedE),
    .srcaE(srcaE), .srcbE(srcbE), .div_cancel(div_cancel),
    .div_stall(div_stall), .div_ready(div_ready),
    .div_hi(div_hi), .div_lo(div_lo),
    .HiLoWriteW(HiLoWriteW), .hi_inW(hi_inW), .lo_inW(lo_inW),
    .hi_o(hi_o), .lo_o(lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sgn;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
  } vec_t;

  vec_t          vecs[$];
  logic [2*W-1:0] sb[$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts a divide at cycle 0 and follows it to the ready pulse.
  task automatic do_div(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sgn, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    int unsigned exp_lat;
    int          cyc, nstall, ready_cyc;
    logic [2*W-1:0] exp_pair;
    exp_lat     = (b == '0) ? 1 : W + 1;
    sb.push_back({exp_hi, exp_lo});
    srcaE       = a;
    srcbE       = b;
    div_signedE = sgn;
    div_startE  = 1'b1;
    nstall      = 0;
    ready_cyc   = -1;
    for (cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (div_stall) nstall++;
      if (div_ready) begin
        ready_cyc = cyc;
        if (sb.size() == 0) begin
          check({name, "_unexpected_ready"}, 1, 0);
        end else begin
          exp_pair = sb.pop_front();
          check({name, "_lo"}, div_lo, exp_pair[W-1:0]);
          check({name, "_hi"}, div_hi, exp_pair[2*W-1:W]);
        end
        break;
      end
      step();
      // Operands must already be latched; scramble them while busy.
      srcaE = $urandom;
      srcbE = $urandom;
    end
    check({name, "_ready_cycle"}, ready_cyc, exp_lat);
    check({name, "_stall_cycles"}, nstall, exp_lat);
    step();
    div_startE = 1'b0;
  endtask

  initial begin
    int unsigned ra, rb, nready;
    vecs.push_back('{a: 32'd100,        b: 32'd7,          sgn: 1'b0, lo: 32'd14,         hi: 32'd2});
    vecs.push_back('{a: 32'hFFFFFF9C,   b: 32'd7,          sgn: 1'b1, lo: 32'hFFFFFFF2,   hi: 32'hFFFFFFFE});
    vecs.push_back('{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b1, lo: 32'h80000000,   hi: 32'd0});
    vecs.push_back('{a: 32'd5,          b: 32'd0,          sgn: 1'b0, lo: 32'hFFFFFFFF,   hi: 32'd5});
    vecs.push_back('{a: 32'd100,        b: 32'hFFFFFFF9,   sgn: 1'b1, lo: 32'hFFFFFFF2,   hi: 32'd2});
    vecs.push_back('{a: 32'hFFFFFF9C,   b: 32'hFFFFFFF9,   sgn: 1'b1, lo: 32'd14,         hi: 32'hFFFFFFFE});
    vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'd1,          sgn: 1'b0, lo: 32'hFFFFFFFF,   hi: 32'd0});
    vecs.push_back('{a: 32'hFFFFFFFF,   b: 32'h10,         sgn: 1'b0, lo: 32'h0FFFFFFF,   hi: 32'hF});
    vecs.push_back('{a: 32'hFFFFFFFB,   b: 32'd0,          sgn: 1'b1, lo: 32'hFFFFFFFF,   hi: 32'hFFFFFFFB});
    vecs.push_back('{a: 32'h80000000,   b: 32'hFFFFFFFF,   sgn: 1'b0, lo: 32'd0,          hi: 32'h80000000});
    vecs.push_back('{a: 32'd3,          b: 32'd7,          sgn: 1'b0, lo: 32'd0,          hi: 32'd3});
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom_range(1, 32'h0001FFFF);
      vecs.push_back('{a: ra, b: rb, sgn: 1'b0, lo: ra / rb, hi: ra % rb});
    end

    rst = 1'b0; div_startE = 1'b1; div_signedE = 1'b0; div_cancel = 1'b0;
    srcaE = 32'd9; srcbE = 32'd3; HiLoWriteW = 1'b0; hi_inW = '0; lo_inW = '0;
    #3;
    check("reset_stall", div_stall, 0);
    check("reset_ready", div_ready, 0);
    check("reset_div_hilo", {div_hi, div_lo}, 0);
    check("reset_hi_lo", {hi_o, lo_o}, 0);
    div_startE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();

    foreach (vecs[i])
      do_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].hi, vecs[i].lo);

    repeat (3) step();
    @(negedge clk);
    check("result_held", {div_hi, div_lo}, {32'd0, 32'hFFFFFFFF} ^ {vecs[vecs.size()-1].hi, ~vecs[vecs.size()-1].lo});
    step();

    // Start together with cancel in IDLE must not launch a divide.
    srcaE = 32'd1000; srcbE = 32'd3; div_signedE = 1'b0;
    div_startE = 1'b1; div_cancel = 1'b1;
    @(negedge clk);
    check("start_cancel_stall", div_stall, 0);
    step();
    div_cancel = 1'b0;
    // Cycle 0 of a real divide; cancel at cycle 10.
    for (int c = 1; c <= 10; c++) step();
    div_cancel = 1'b1;
    step();
    div_cancel = 1'b0;
    div_startE = 1'b0;
    @(negedge clk);
    check("cancel_stall", div_stall, 0);
    nready = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (div_ready) nready++;
    end
    check("cancel_no_ready", nready, 0);
    step();
    do_div("after_cancel", 32'd1000, 32'd3, 1'b0, 32'd1, 32'd333);

    HiLoWriteW = 1'b1; hi_inW = 32'hA5; lo_inW = 32'h5A;
    @(negedge clk);
    check("hilo_bypass", {hi_o, lo_o}, {32'hA5, 32'h5A});
    step();
    HiLoWriteW = 1'b0; hi_inW = 32'h1111; lo_inW = 32'h2222;
    @(negedge clk);
    check("hilo_held", {hi_o, lo_o}, {32'hA5, 32'h5A});
    step();
    HiLoWriteW = 1'b1; hi_inW = 32'h1234; lo_inW = 32'h5678;
    #1;
    check("hilo_bypass_over_reg", {hi_o, lo_o}, {32'h1234, 32'h5678});
    HiLoWriteW = 1'b0;
    #1;
    check("hilo_reg_unchanged", {hi_o, lo_o}, {32'hA5, 32'h5A});
    step();

    // Reset at cycle 15 of a divide.
    srcaE = 32'd1000; srcbE = 32'd3; div_signedE = 1'b0; div_startE = 1'b1;
    for (int c = 1; c <= 15; c++) step();
    rst = 1'b0;
    #1;
    check("midreset_stall", div_stall, 0);
    check("midreset_ready", div_ready, 0);
    check("midreset_hi_lo", {hi_o, lo_o}, 0);
    check("midreset_div_hilo", {div_hi, div_lo}, 0);
    div_startE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step();
    do_div("after_reset", 32'd50, 32'd8, 1'b0, 32'd2, 32'd6);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
